fiveway_q31demux_regbank: RTL
=============================

Name: fiveway_Q31demux_regbank

Overview:
Registered 1-to-5 distributor for Q31 words. It is the write-side counterpart of the five-input Q31 selector used in the pre-processor datapath. A single Q31 result bus (multiplier/adder output) is steered into one of five holding registers, either by direct select or by an auto-incrementing burst. The five registers then feed the five-input selector, filter taps or state memories downstream.

Parameters:
WIDTH, 32, data width of input and every holding register (Q31 format)
NUM_DEST, 5, number of destination registers; fixed at 5, not to be overridden

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in  input  32  Q31 data to be written
sel  input  3  destination index (single write) or start index (burst)
wr  input  1  write strobe, one word per cycle when high
burst_start  input  1  begin auto-increment burst at index sel
clr  input  1  synchronous clear of all registers and valid flags
out0..out4  output  32 each  holding registers 0..4
valid  output  5  bit k high when outk written since last reset/clr
busy  output  1  high while in BURST state
done  output  1  one-cycle pulse after final burst write (to out4)

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-high, ports named clock and reset. Reset forces out0..out4=0, valid=0, busy=0, done=0, ptr=0, state=IDLE.
- Index decode: sel 0..3 map to out0..out3. Any sel value 4..7 maps to out4. The same rule applies to the burst start index (ptr clamped to 4).
- Write latency: data on in with wr high at edge N appears on the selected outk and sets valid[k] after edge N. Registers hold their value when not written. Data is stored unmodified; no saturation or rounding.
- Priority within one cycle: clr > burst_start > wr.
  - clr: all out=0, valid=0, state=IDLE, busy=0, done=0, ptr=0. A coincident wr is discarded.
  - burst_start: coincident wr is ignored; burst_start only loads ptr.
- FSM states:
  - IDLE: busy=0.
    - wr writes out[decode(sel)].
    - burst_start -> BURST, ptr=decode(sel), busy=1 from next cycle.
  - BURST: busy=1; sel ignored.
    - Each wr cycle writes out[ptr], sets valid[ptr], increments ptr.
    - Cycles with wr low: no write, ptr holds.
    - Write with ptr==4: done=1 for exactly the next cycle, state -> IDLE, busy=0, ptr=0.
    - burst_start while in BURST restarts: ptr=decode(sel), no write that cycle, previous writes retained, no done.
- done is low at all times except the single post-completion cycle. A burst started at index 4 completes after one write.
- Reset mid-burst: immediate asynchronous return to reset state; partial data is lost.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out0..out4=0x00000000, valid=5'b00000, busy=0, done=0 immediately, without waiting for a clock edge.
- Single writes: wr with sel=0..3 and in=0x11111111..0x44444444, then sel=6 with in=0x80000000 -> out0..out3 hold those values, out4=0x80000000, valid=5'b11111.
- Full burst: burst_start sel=0, then 5 wr cycles in=0x7FFFFFFF,0x00000001,0xFFFFFFFF,0x40000000,0xC0000000 with wr low for one cycle after the 2nd word -> registers in order, busy high for 6 cycles, done pulses once the cycle after the 5th write.
- Partial burst and clamping: burst_start sel=7 then wr in=0x12345678 -> only out4 written, valid[4]=1, done pulses after one write.
- Priority: in IDLE, clr+wr sel=2 in=0x55555555 -> nothing written, all cleared. burst_start+wr same cycle -> no write, state=BURST.
- Restart and reset mid-burst: burst_start sel=1, write 2 words, burst_start sel=3 -> next write lands in out3, no done until out4 written. Separately, reset after 2 words -> busy=0, all out=0.

Source files
------------

// File: rtl/fiveway_q31demux_regbank.sv
// Registered 1-to-5 distributor for Q31 words.
// Direct writes by select, or auto-incrementing bursts that end at out4.
module fiveway_q31demux_regbank #(
    parameter int WIDTH    = 32,
    parameter int NUM_DEST = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    input  logic             wr,
    input  logic             burst_start,
    input  logic             clr,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [4:0]       valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       ptr, ptr_nx;
    logic             done_nx;
    logic             we;
    logic             wipe;
    logic [2:0]       widx;
    logic [WIDTH-1:0] regs [NUM_DEST];

    // Indices above 3 all collapse onto the last register.
    function automatic logic [2:0] dec(input logic [2:0] s);
        return (s > 3'd3) ? 3'd4 : s;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        done_nx  = 1'b0;
        we       = 1'b0;
        wipe     = 1'b0;
        widx     = '0;
        priority case (1'b1)
            clr: begin
                wipe     = 1'b1;
                state_nx = IDLE;
                ptr_nx   = '0;
            end
            burst_start: begin
                state_nx = BURST;
                ptr_nx   = dec(sel);
            end
            wr: begin
                we = 1'b1;
                if (state == IDLE) begin
                    widx = dec(sel);
                end else begin
                    widx = ptr;
                    if (ptr == 3'd4) begin
                        state_nx = IDLE;
                        ptr_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        ptr_nx = ptr + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_DEST; k++) regs[k] <= '0;
            valid <= '0;
        end else if (wipe) begin
            for (int k = 0; k < NUM_DEST; k++) regs[k] <= '0;
            valid <= '0;
        end else if (we) begin
            regs[widx]  <= in;
            valid[widx] <= 1'b1;
        end
    end

    assign busy = (state == BURST);
    assign out0 = regs[0];
    assign out1 = regs[1];
    assign out2 = regs[2];
    assign out3 = regs[3];
    assign out4 = regs[4];

endmodule
